// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin register-file write-back arbiter with pending-write scoreboard
// Optional feature macro: WB_BYPASS_EN (adds Rs1_Fwd/Rs2_Fwd/Fwd_Data forwarding outputs)
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        Req_Valid,
  output logic [NUM_REQ-1:0]        Req_Ready,
  input  logic [NUM_REQ*ADDR_W-1:0] Req_Rd,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  input  logic                      Wb_Hold,
  input  logic                      Reserve_Valid,
  input  logic [ADDR_W-1:0]         Reserve_Rd,
  input  logic [ADDR_W-1:0]         Rs1,
  input  logic [ADDR_W-1:0]         Rs2,
  output logic                      Rs1_Busy,
  output logic                      Rs2_Busy,
`ifdef WB_BYPASS_EN
  output logic                      Rs1_Fwd,
  output logic                      Rs2_Fwd,
  output logic [DATA_W-1:0]         Fwd_Data,
`endif
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteRegister,
  output logic [DATA_W-1:0]         WriteData
);

  localparam int PTR_W    = $clog2(NUM_REQ);
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptrNext;
  logic [PTR_W:0]      cand;
  logic [PTR_W-1:0]    grantIdx;
  logic                grantValid;
  logic [ADDR_W-1:0]   selRd;
  logic [DATA_W-1:0]   selData;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;

  // Round-robin search starting at ptr; the first valid requester wins unless stalled or in reset
  always_comb begin
    cand       = '0;
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!grantValid && Req_Valid[cand[PTR_W-1:0]]) begin
        grantValid = 1'b1;
        grantIdx   = cand[PTR_W-1:0];
      end
    end
    if (!Reset_n || Wb_Hold) begin
      grantValid = 1'b0;
    end
  end

  // One-hot ready towards the granted requester; a grant always coincides with a transfer
  always_comb begin
    Req_Ready = '0;
    if (grantValid) begin
      Req_Ready[grantIdx] = 1'b1;
    end
  end

  // Select the winning requester's destination and data, and the pointer value after it
  always_comb begin
    selRd   = Req_Rd[int'(grantIdx)*ADDR_W +: ADDR_W];
    selData = Req_Data[int'(grantIdx)*DATA_W +: DATA_W];
    if (grantIdx == PTR_W'(NUM_REQ-1)) begin
      ptrNext = '0;
    end else begin
      ptrNext = grantIdx + 1'b1;
    end
  end

  // Pointer moves past the requester just served so every requester gets a turn
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr <= '0;
    end else if (grantValid) begin
      ptr <= ptrNext;
    end
  end

  // Registered write port; x0 transfers complete the handshake but never raise RegWrite
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (grantValid) begin
      RegWrite      <= (selRd != '0);
      WriteRegister <= selRd;
      WriteData     <= selData;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  // Scoreboard update: clear on write-back, then set on reservation so a newer claim wins
  always_comb begin
    busyNext = busy;
    if (grantValid && (selRd != '0)) begin
      busyNext[selRd] = 1'b0;
    end
    if (Reserve_Valid && (Reserve_Rd != '0)) begin
      busyNext[Reserve_Rd] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  // Scoreboard state, cleared by reset so in-flight claims are forgotten
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  // Hazard lookup; x0 reads zero because bit 0 is never set
  always_comb begin
    Rs1_Busy = busy[Rs1];
    Rs2_Busy = busy[Rs2];
  end

`ifdef WB_BYPASS_EN
  // Forward the value currently on the write port. The busy bit was already cleared on the
  // edge that loaded this write, so a set bit here only means a newer producer re-reserved it.
  always_comb begin
    Rs1_Fwd  = RegWrite && (WriteRegister == Rs1) && (Rs1 != '0);
    Rs2_Fwd  = RegWrite && (WriteRegister == Rs2) && (Rs2 != '0);
    Fwd_Data = WriteData;
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ write-back requesters (ALU, load unit, CSR, ...) using round-robin arbitration.
- Drives the register file's RegWrite/WriteRegister/WriteData from a registered output stage.
- Keeps a pending-write scoreboard so the issue stage can detect RAW hazards on ReadRegister1/ReadRegister2.
- Sits between the execute/memory units and the register file.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8).
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (32 registers, x0 hard-wired zero).

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Req_Valid  in  NUM_REQ  per-requester write request.
- Req_Ready  out  NUM_REQ  per-requester grant. Combinational, one-hot or zero.
- Req_Rd  in  NUM_REQ*ADDR_W  packed destination indices; requester i uses bits [i*ADDR_W +: ADDR_W].
- Req_Data  in  NUM_REQ*DATA_W  packed write data; same packing as Req_Rd.
- Wb_Hold  in  1  global stall; no grants while high.
- Reserve_Valid  in  1  issue stage claims a destination register.
- Reserve_Rd  in  ADDR_W  register being claimed.
- Rs1  in  ADDR_W  hazard query index 1.
- Rs2  in  ADDR_W  hazard query index 2.
- Rs1_Busy  out  1  Rs1 has a pending write.
- Rs2_Busy  out  1  Rs2 has a pending write.
- RegWrite  out  1  register-file write enable (registered).
- WriteRegister  out  ADDR_W  register-file write index (registered).
- WriteData  out  DATA_W  register-file write data (registered).

Behaviour:
- Reset (async, Reset_n low):
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - RR pointer ptr=0.
  - All scoreboard busy bits = 0.
  - Req_Ready=0 while in reset.
- Arbitration (combinational, each cycle):
  - If Wb_Hold=1: Req_Ready=0.
  - Otherwise: search indices ptr, ptr+1, ..., wrapping modulo NUM_REQ, and grant the first i with Req_Valid[i]=1. Req_Ready[i]=1 for that i only.
  - Transfer occurs when Req_Valid[i] & Req_Ready[i].
- Pointer update:
  - On a transfer from i: ptr <= (i+1) mod NUM_REQ.
  - No transfer: ptr holds.
- Output stage, 1-cycle latency:
  - On a transfer: WriteRegister <= Req_Rd[i], WriteData <= Req_Data[i], RegWrite <= (Req_Rd[i] != 0).
  - No transfer: RegWrite <= 0; WriteRegister/WriteData hold their last values.
- x0 requests:
  - Accepted (handshake completes, ptr advances), but no write is issued.
  - Busy bits are unaffected.
- Scoreboard: busy[1..31], with busy[0] constant 0.
  - Set: Reserve_Valid=1 and Reserve_Rd!=0 -> busy[Reserve_Rd] <= 1.
  - Clear: a transfer with Req_Rd=r, r!=0 -> busy[r] <= 0, in the same edge as the output register load.
  - Same register set and cleared in one cycle: set wins (a newer producer has claimed it).
  - Reserve of x0: ignored.
- Busy outputs:
  - Rs1_Busy = busy[Rs1], Rs2_Busy = busy[Rs2]; combinational from the state.
  - Rs1/Rs2 = 0 always reads busy=0.
- Held requester: must keep Req_Valid/Req_Rd/Req_Data stable until granted. The block does not check this.
- Reset mid-transfer: the in-flight output write is dropped (RegWrite=0) and the scoreboard is cleared.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs Rs1_Fwd (1), Rs2_Fwd (1), Fwd_Data (DATA_W).
  - RsN_Fwd=1 when RegWrite=1, WriteRegister==RsN and RsN!=0; Fwd_Data=WriteData.
  - RsN_Busy is forced 0 whenever RsN_Fwd=1, unless the same register was re-reserved after this write (busy bit set again).
- Undefined: these ports are absent and Busy behaves as above.

Test Plan:
- Reset: Reset_n=0 with Req_Valid=3'b111 -> Req_Ready=0, RegWrite=0. After release, grant goes to requester 0.
- Round-robin: all three requesters continuously valid, with rd=5/6/7 and data A/B/C -> Req_Ready sequence 001,010,100,001. RegWrite=1 each cycle from cycle 2 on, with WriteRegister 5,6,7,5 one cycle after each grant.
- x0 suppression: only requester 1 valid with rd=0, data=32'hDEADBEEF -> Req_Ready[1]=1, next cycle RegWrite=0, ptr=2.
- Hold: Wb_Hold=1 for 3 cycles with requester 2 valid -> Req_Ready=0 and RegWrite=0 throughout. Wb_Hold=0 -> grant to 2, write one cycle later.
- Scoreboard sequence:
  - Reserve rd=9 -> Rs1=9 busy next cycle.
  - Requester 0 writes rd=9 -> Rs1_Busy=0 after that edge.
  - Reserve rd=9 in the same cycle as a write to rd=9 -> Rs1_Busy stays 1.
- WB_BYPASS_EN: write rd=12, data=32'h1234 while Rs2=12 -> in the RegWrite cycle, Rs2_Fwd=1, Fwd_Data=32'h1234, Rs2_Busy=0.
